pipeline_sequencer: RTL and testbench

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

---
 rtl/pipe_ctrl_pkg.sv | 31 +++
 rtl/sat_counter.sv | 25 ++
 rtl/pipeline_sequencer.sv | 141 ++++++++++++++
 tb/tb_pipeline_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: state encoding, counter widths
// and the bundle of pipeline control enables.
package pipe_ctrl_pkg;

  localparam int CNT_W  = 16;
  localparam int WAIT_W = 8;
  localparam int INIT_W = 4;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic pipe_hold;
    logic ifid_flush;
    logic exmem_flush;
    logic hazard;
  } ctrl_t;

  // Field order: pc_write, ifid_write, pipe_hold, ifid_flush, exmem_flush, hazard
  localparam ctrl_t CTRL_INIT      = 6'b000111;
  localparam ctrl_t CTRL_MEM_STALL = 6'b001000;
  localparam ctrl_t CTRL_BRANCH    = 6'b110111;
  localparam ctrl_t CTRL_LOAD_USE  = 6'b000001;
  localparam ctrl_t CTRL_NORMAL    = 6'b110000;

endpackage

// File: rtl/sat_counter.sv
// Event counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + WIDTH'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Hazard/stall/flush sequencer for a 5-stage pipeline: post-reset bubbles,
// memory-wait holds, branch flushes and load-use stalls, plus event counters.
module pipeline_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_Rt,
  input  logic        MEM_BranchTaken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IFID_Write,
  output logic        pipe_hold,
  output logic        IFID_Flush,
  output logic        EXMEM_Flush,
  output logic        hazard_detected,
  output logic [1:0]  seq_state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        mem_timeout
);

  localparam logic [INIT_W-1:0] INIT_LOAD   = INIT_W'(INIT_CYCLES);
  localparam logic [WAIT_W:0]   TIMEOUT_LIM = (WAIT_W + 1)'(MEM_TIMEOUT);

  seq_state_t          state_q;
  seq_state_t          state_nxt;
  logic [INIT_W-1:0]   init_cnt_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic [WAIT_W:0]     wait_cnt_inc;
  logic                timeout_q;
  ctrl_t               ctrl;
  logic                mem_stall;
  logic                load_use;
  logic                eval_run;
  logic                stall_inc;
  logic                flush_inc;

  assign mem_stall    = mem_req && !mem_ready;
  assign load_use     = EX_MemRead && (EX_Rt != 5'd0) &&
                        ((EX_Rt == ID_Rs) || (EX_Rt == ID_Rt));
  assign wait_cnt_inc = {1'b0, wait_cnt_q} + (WAIT_W + 1)'(1);

  // Control decode: zero-latency from state and same-cycle hazard inputs
  always_comb begin
    ctrl      = CTRL_INIT;
    state_nxt = state_q;
    eval_run  = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_INIT: begin
          if (init_cnt_q <= INIT_W'(1)) state_nxt = ST_RUN;
        end
        ST_RUN: eval_run = 1'b1;
        ST_MEM_WAIT: begin
          if (!mem_ready) begin
            ctrl      = CTRL_MEM_STALL;
            stall_inc = 1'b1;
          end else begin
            eval_run = 1'b1;
          end
        end
        default: state_nxt = ST_INIT;
      endcase

      // Branch outranks load-use; a pending memory access outranks both
      if (eval_run) begin
        state_nxt = ST_RUN;
        if (mem_stall) begin
          ctrl      = CTRL_MEM_STALL;
          stall_inc = 1'b1;
          state_nxt = ST_MEM_WAIT;
        end else if (MEM_BranchTaken) begin
          ctrl      = CTRL_BRANCH;
          flush_inc = 1'b1;
        end else if (load_use) begin
          ctrl      = CTRL_LOAD_USE;
          stall_inc = 1'b1;
        end else begin
          ctrl = CTRL_NORMAL;
        end
      end
    end
  end

  // State, bubble countdown and memory-wait watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= INIT_LOAD;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (state_q == ST_INIT) begin
        if (init_cnt_q > INIT_W'(1)) init_cnt_q <= init_cnt_q - 1'b1;
      end else if (state_nxt == ST_INIT) begin
        init_cnt_q <= INIT_LOAD;
      end
      if (state_q == ST_MEM_WAIT && !mem_ready) begin
        if (!(&wait_cnt_q)) wait_cnt_q <= wait_cnt_inc[WAIT_W-1:0];
        if (wait_cnt_inc >= TIMEOUT_LIM) timeout_q <= 1'b1;
      end else begin
        wait_cnt_q <= '0;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  assign PCWrite         = ctrl.pc_write;
  assign IFID_Write      = ctrl.ifid_write;
  assign pipe_hold       = ctrl.pipe_hold;
  assign IFID_Flush      = ctrl.ifid_flush;
  assign EXMEM_Flush     = ctrl.exmem_flush;
  assign hazard_detected = ctrl.hazard;
  assign seq_state       = state_q;
  assign mem_timeout     = timeout_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer (INIT_CYCLES=4, MEM_TIMEOUT=4).
module tb_pipeline_sequencer;

  localparam logic [5:0] E_INIT  = 6'b000111;
  localparam logic [5:0] E_STALL = 6'b001000;
  localparam logic [5:0] E_FLUSH = 6'b110111;
  localparam logic [5:0] E_LU    = 6'b000001;
  localparam logic [5:0] E_NORM  = 6'b110000;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ID_Rs, ID_Rt, EX_Rt;
  logic        EX_MemRead, MEM_BranchTaken, mem_req, mem_ready;
  logic        PCWrite, IFID_Write, pipe_hold, IFID_Flush, EXMEM_Flush, hazard_detected;
  logic [1:0]  seq_state;
  logic [15:0] stall_cnt, flush_cnt;
  logic        mem_timeout;

  pipeline_sequencer #(.INIT_CYCLES(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .EX_MemRead(EX_MemRead),
    .EX_Rt(EX_Rt), .MEM_BranchTaken(MEM_BranchTaken), .mem_req(mem_req),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IFID_Write(IFID_Write),
    .pipe_hold(pipe_hold), .IFID_Flush(IFID_Flush), .EXMEM_Flush(EXMEM_Flush),
    .hazard_detected(hazard_detected), .seq_state(seq_state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rd;
    logic [4:0] ex_rt, rs, rt;
    logic       br, req, rdy;
    logic [5:0] ctrl;
    logic [1:0] st;
    int         ds, df;
  } stim_t;

  typedef struct packed {
    logic [5:0] ctrl;
    logic [1:0] st;
  } exp_t;

  exp_t        sbq[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_stall = 0;
  logic [15:0] exp_flush = 0;

  function automatic stim_t mk(logic rd, logic [4:0] ex_rt, logic [4:0] rs, logic [4:0] rt,
                               logic br, logic req, logic rdy, logic [5:0] ctrl,
                               logic [1:0] st, int ds, int df);
    stim_t s;
    s.rd = rd; s.ex_rt = ex_rt; s.rs = rs; s.rt = rt; s.br = br; s.req = req; s.rdy = rdy;
    s.ctrl = ctrl; s.st = st; s.ds = ds; s.df = df;
    return s;
  endfunction

  function automatic logic [5:0] outs();
    return {PCWrite, IFID_Write, pipe_hold, IFID_Flush, EXMEM_Flush, hazard_detected};
  endfunction

  task automatic drive(input stim_t s);
    EX_MemRead = s.rd; EX_Rt = s.ex_rt; ID_Rs = s.rs; ID_Rt = s.rt;
    MEM_BranchTaken = s.br; mem_req = s.req; mem_ready = s.rdy;
    sbq.push_back({s.ctrl, s.st});
    exp_stall = exp_stall + 16'(s.ds);
    exp_flush = exp_flush + 16'(s.df);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, E_INIT, 2'd0, 0, 0));
    void'(sbq.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    exp_stall = 0;
    exp_flush = 0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, E_INIT, 2'd0, 0, 0));
    @(posedge clk); #1;
    e = sbq.pop_front();
    n_vec++;
    if ({outs(), seq_state, stall_cnt, flush_cnt, mem_timeout} !== {e.ctrl, e.st, 33'd0}) begin
      n_err++;
      $display("FAIL reset got ctrl=%b st=%0d sc=%h fc=%h to=%b exp ctrl=%b st=0 counters 0",
               outs(), seq_state, stall_cnt, flush_cnt, mem_timeout, e.ctrl);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(mk(0, 0, 0, 0, 0, 0, 0, (i < 4) ? E_INIT : E_NORM, (i < 4) ? 2'd0 : 2'd1, 0, 0));
      #1;
      e = sbq.pop_front();
      n_vec++;
      if ({outs(), seq_state} !== {e.ctrl, e.st}) begin
        n_err++;
        $display("FAIL init_seq[%0d] got ctrl=%b st=%0d exp ctrl=%b st=%0d", i, outs(), seq_state, e.ctrl, e.st);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t rows[$];
    exp_t  e;
    rows.push_back(mk(1, 5, 5, 0, 0, 0, 0, E_LU,   2'd1, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_NORM, 2'd1, 0, 0));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, E_NORM, 2'd1, 0, 0));
    rows.push_back(mk(1, 7, 3, 7, 0, 0, 0, E_LU,   2'd1, 1, 0));
    rows.push_back(mk(0, 7, 7, 7, 0, 0, 0, E_NORM, 2'd1, 0, 0));
    rows.push_back(mk(1, 7, 3, 4, 0, 0, 0, E_NORM, 2'd1, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #1;
      e = sbq.pop_front();
      n_vec++;
      if ({outs(), seq_state} !== {e.ctrl, e.st}) begin
        n_err++;
        $display("FAIL load_use[%0d] got ctrl=%b st=%0d exp ctrl=%b st=%0d", i, outs(), seq_state, e.ctrl, e.st);
      end
      @(posedge clk); #1;
      n_vec++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
        n_err++;
        $display("FAIL load_use_cnt[%0d] got sc=%h fc=%h exp sc=%h fc=%h", i, stall_cnt, flush_cnt, exp_stall, exp_flush);
      end
    end
  endtask

  task automatic test_branch();
    stim_t rows[$];
    exp_t  e;
    do_reset();
    rows.push_back(mk(1, 5, 5, 0, 1, 0, 0, E_FLUSH, 2'd1, 0, 1));
    rows.push_back(mk(0, 0, 0, 0, 1, 0, 0, E_FLUSH, 2'd1, 0, 1));
    rows.push_back(mk(0, 0, 0, 0, 1, 1, 1, E_FLUSH, 2'd1, 0, 1));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_NORM,  2'd1, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #1;
      e = sbq.pop_front();
      n_vec++;
      if ({outs(), seq_state} !== {e.ctrl, e.st}) begin
        n_err++;
        $display("FAIL branch[%0d] got ctrl=%b st=%0d exp ctrl=%b st=%0d", i, outs(), seq_state, e.ctrl, e.st);
      end
      @(posedge clk); #1;
      n_vec++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
        n_err++;
        $display("FAIL branch_cnt[%0d] got sc=%h fc=%h exp sc=%h fc=%h", i, stall_cnt, flush_cnt, exp_stall, exp_flush);
      end
    end
  endtask

  task automatic test_mem_stall();
    stim_t rows[$];
    exp_t  e;
    do_reset();
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 0, E_STALL, 2'd1, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 0, E_STALL, 2'd2, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 0, E_STALL, 2'd2, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 1, E_NORM,  2'd2, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_NORM,  2'd1, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 1, 1, 0, E_STALL, 2'd1, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 1, 0, 0, E_STALL, 2'd2, 1, 0));
    rows.push_back(mk(1, 5, 5, 0, 1, 1, 1, E_FLUSH, 2'd2, 0, 1));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_NORM,  2'd1, 0, 0));
    rows.push_back(mk(1, 9, 9, 0, 0, 1, 0, E_STALL, 2'd1, 1, 0));
    rows.push_back(mk(1, 9, 0, 9, 0, 1, 1, E_LU,    2'd2, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_NORM,  2'd1, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      #1;
      e = sbq.pop_front();
      n_vec++;
      if ({outs(), seq_state} !== {e.ctrl, e.st}) begin
        n_err++;
        $display("FAIL mem_stall[%0d] got ctrl=%b st=%0d exp ctrl=%b st=%0d", i, outs(), seq_state, e.ctrl, e.st);
      end
      @(posedge clk); #1;
      n_vec++;
      if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
        n_err++;
        $display("FAIL mem_stall_cnt[%0d] got sc=%h fc=%h exp sc=%h fc=%h", i, stall_cnt, flush_cnt, exp_stall, exp_flush);
      end
    end
  endtask

  task automatic test_timeout();
    stim_t rows[$];
    exp_t  e;
    int    waits = 0;
    logic  exp_to = 1'b0;
    do_reset();
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 0, E_STALL, 2'd1, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 0, E_STALL, 2'd2, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 0, E_STALL, 2'd2, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 0, E_STALL, 2'd2, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 1, 1, E_NORM,  2'd2, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_NORM,  2'd1, 0, 0));
    for (int k = 0; k < 10; k++)
      rows.push_back(mk(0, 0, 0, 0, 0, 1, 0, E_STALL, (k == 0) ? 2'd1 : 2'd2, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, E_NORM, 2'd2, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_NORM, 2'd1, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, E_NORM, 2'd1, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]);
      if (rows[i].st == 2'd2 && !rows[i].rdy) waits++;
      else waits = 0;
      if (waits >= 4) exp_to = 1'b1;
      #1;
      e = sbq.pop_front();
      n_vec++;
      if ({outs(), seq_state} !== {e.ctrl, e.st}) begin
        n_err++;
        $display("FAIL timeout_seq[%0d] got ctrl=%b st=%0d exp ctrl=%b st=%0d", i, outs(), seq_state, e.ctrl, e.st);
      end
      @(posedge clk); #1;
      n_vec++;
      if (mem_timeout !== exp_to || stall_cnt !== exp_stall) begin
        n_err++;
        $display("FAIL timeout_flag[%0d] got to=%b sc=%h exp to=%b sc=%h", i, mem_timeout, stall_cnt, exp_to, exp_stall);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    drive(mk(0, 0, 0, 0, 0, 1, 0, E_STALL, 2'd1, 1, 0));
    @(posedge clk); #1;
    drive(mk(0, 0, 0, 0, 0, 1, 0, E_STALL, 2'd2, 1, 0));
    #1;
    e = sbq.pop_front();
    e = sbq.pop_front();
    n_vec++;
    if ({outs(), seq_state} !== {e.ctrl, e.st}) begin
      n_err++;
      $display("FAIL reset_mid_wait got ctrl=%b st=%0d exp ctrl=%b st=%0d", outs(), seq_state, e.ctrl, e.st);
    end
    rst = 1'b1;
    drive(mk(1, 5, 5, 0, 1, 1, 0, E_INIT, 2'd2, 0, 0));
    #1;
    e = sbq.pop_front();
    n_vec++;
    if (outs() !== e.ctrl) begin
      n_err++;
      $display("FAIL reset_mid_outs got ctrl=%b exp ctrl=%b", outs(), e.ctrl);
    end
    @(posedge clk); #1;
    exp_stall = 0;
    exp_flush = 0;
    n_vec++;
    if ({seq_state, stall_cnt, flush_cnt, mem_timeout} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_mid_clear got st=%0d sc=%h fc=%h to=%b exp all 0", seq_state, stall_cnt, flush_cnt, mem_timeout);
    end
    rst = 1'b0;
    // Two INIT cycles, reset again, then the full INIT sequence must restart
    for (int i = 0; i < 8; i++) begin
      rst = (i == 2);
      drive(mk(0, 0, 0, 0, 0, 0, 0, (i < 7) ? E_INIT : E_NORM, (i < 7) ? 2'd0 : 2'd1, 0, 0));
      #1;
      e = sbq.pop_front();
      n_vec++;
      if ({outs(), seq_state} !== {e.ctrl, e.st}) begin
        n_err++;
        $display("FAIL reset_mid_init[%0d] got ctrl=%b st=%0d exp ctrl=%b st=%0d", i, outs(), seq_state, e.ctrl, e.st);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    EX_MemRead = 0; EX_Rt = 0; ID_Rs = 0; ID_Rt = 0; MEM_BranchTaken = 0;
    mem_req = 1'b1; mem_ready = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    n_vec++;
    if (stall_cnt !== 16'hFFFE) begin
      n_err++;
      $display("FAIL sat_pre got sc=%h exp sc=fffe", stall_cnt);
    end
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (stall_cnt !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sat_max got sc=%h exp sc=ffff", stall_cnt);
    end
    @(posedge clk); #1;
    n_vec++;
    if (stall_cnt !== 16'hFFFF || flush_cnt !== 16'h0000) begin
      n_err++;
      $display("FAIL sat_hold got sc=%h fc=%h exp sc=ffff fc=0000", stall_cnt, flush_cnt);
    end
    mem_req = 1'b0;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    EX_MemRead = 0; EX_Rt = 0; ID_Rs = 0; ID_Rt = 0;
    MEM_BranchTaken = 0; mem_req = 0; mem_ready = 0;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_stall();
    test_timeout();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
